key_conditioner: RTL

- Front end for the four clock-setting push-buttons.
- Synchronises and debounces the raw board keys, and emits one-clock press pulses on key1..key4 for the time-setting stage that follows.
- Optionally auto-repeats held keys, so a held increment key steps the digits continuously.
- Pure control path: no time arithmetic.

---
 rtl/key_conditioner.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Front end for the four clock-setting push-buttons. Each raw key is
// normalised to "pressed = 1", synchronised through two flops, debounced, and
// turned into single-clock press pulses. Keys enabled in REPEAT_MASK also emit
// auto-repeat pulses while they stay held. The four channels are independent
// copies of the same logic; there is no priority between keys.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-low reset
//   key_raw   raw button levels; bit0 -> key1 ... bit3 -> key4
//   key1..4   single-clock press / repeat pulse per channel
//   key_held  debounced pressed level per channel
//
// Handshake: none. key1..key4 are fire-and-forget pulses with no ready path;
// the consumer must sample them on every clock.
//
// Per-channel control state (FSM state, repeat counter, pulse register) is
// kept in one packed struct, g_chan[i].ctl, so it can be probed directly.
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int unsigned DEB_CYCLES     = 500000,   // stable clocks before a level is accepted, >= 2
    parameter int unsigned REPEAT_DELAY   = 25000000, // press pulse to first repeat pulse, >= 1
    parameter int unsigned REPEAT_PERIOD  = 5000000,  // spacing of later repeat pulses, >= 1
    parameter logic [3:0]  REPEAT_MASK    = 4'b0110,  // bit i enables auto-repeat on key i+1
    parameter bit          KEY_ACTIVE_LOW = 1'b1      // 1: raw key reads 0 when pressed
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_raw,
    output logic       key1,
    output logic       key2,
    output logic       key3,
    output logic       key4,
    output logic [3:0] key_held
);

    // The repeat counter only ever counts up to the larger of the two
    // intervals minus one, so it is sized for that value.
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam int unsigned DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REP = 2'd1,
        REPEAT   = 2'd2
    } rep_state_t;

    typedef struct packed {
        rep_state_t       state;
        logic [REP_W-1:0] rep_cnt;
        logic             pulse;
    } chan_ctl_t;

    logic [3:0] key_norm;
    logic [3:0] pulse_vec;
    logic [3:0] held_vec;

    // Internally a pressed key is always 1.
    assign key_norm = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic             sync1;
        logic             sync2;
        logic             deb;
        logic [DEB_W-1:0] deb_cnt;
        logic             differs;
        logic             accept;
        logic             press_acc;
        logic             rel_acc;
        chan_ctl_t        ctl;
        chan_ctl_t        ctl_next;

        // Two-flop synchroniser; reset value is "released".
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= key_norm[i];
                sync2 <= sync1;
            end
        end

        // A new level is accepted on the edge where it has already differed
        // from the debounced state for DEB_CYCLES-1 consecutive clocks and
        // still differs. Any return to the debounced level restarts the run.
        assign differs   = sync2 ^ deb;
        assign accept    = differs && (deb_cnt == DEB_LAST);
        assign press_acc = accept && sync2;
        assign rel_acc   = accept && !sync2;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                deb     <= 1'b0;
                deb_cnt <= '0;
            end else if (!differs) begin
                deb_cnt <= '0;
            end else if (accept) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end

        // Pulse FSM state register. The pulse is registered on the same edge
        // that accepts the press, so it is visible right after that edge.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ctl <= '{state: IDLE, rep_cnt: '0, pulse: 1'b0};
            end else begin
                ctl <= ctl_next;
            end
        end

        // Pulse FSM next-state logic. A release accepted on the same edge as
        // a due repeat wins: the channel returns to IDLE without a pulse.
        // Keys without auto-repeat park in WAIT_REP with the counter frozen.
        always_comb begin
            ctl_next       = ctl;
            ctl_next.pulse = 1'b0;
            if (rel_acc) begin
                ctl_next.state   = IDLE;
                ctl_next.rep_cnt = '0;
            end else begin
                unique case (ctl.state)
                    IDLE: begin
                        if (press_acc) begin
                            ctl_next.pulse   = 1'b1;
                            ctl_next.rep_cnt = '0;
                            ctl_next.state   = WAIT_REP;
                        end
                    end
                    WAIT_REP: begin
                        if (REPEAT_MASK[i]) begin
                            if (ctl.rep_cnt == DELAY_LAST) begin
                                ctl_next.pulse   = 1'b1;
                                ctl_next.rep_cnt = '0;
                                ctl_next.state   = REPEAT;
                            end else begin
                                ctl_next.rep_cnt = ctl.rep_cnt + REP_W'(1);
                            end
                        end
                    end
                    REPEAT: begin
                        if (ctl.rep_cnt == PERIOD_LAST) begin
                            ctl_next.pulse   = 1'b1;
                            ctl_next.rep_cnt = '0;
                        end else begin
                            ctl_next.rep_cnt = ctl.rep_cnt + REP_W'(1);
                        end
                    end
                    default: begin
                        ctl_next.state   = IDLE;
                        ctl_next.rep_cnt = '0;
                    end
                endcase
            end
        end

        assign pulse_vec[i] = ctl.pulse;
        assign held_vec[i]  = deb;
    end

    assign key1     = pulse_vec[0];
    assign key2     = pulse_vec[1];
    assign key3     = pulse_vec[2];
    assign key4     = pulse_vec[3];
    assign key_held = held_vec;

endmodule
